// File: rtl/rv32_mem.sv
// rv32_mem: memory-access stage. Resolves the branch redirect, runs data-memory
// loads/stores over a valid/ready bus, aligns and extends load data, and
// registers the writeback. While an access is outstanding it stalls upstream.
module rv32_mem (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic        mem_fence_in,
    input  logic [1:0]  branch_op_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        stall_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_pc_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] hold_q, hold_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_write_q, rd_write_d;
    logic [31:0] rd_value_q, rd_value_d;

    logic        req;
    logic        strobe_en;
    logic [31:0] load_data;
    logic [31:0] wb_load_value;

    // Byte-lane enables: half ignores addr[0], word ignores addr[1:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] addr);
        case (width)
            2'b00:   return 4'b0001 << addr;
            2'b01:   return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the mask alone picks the bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] value);
        case (width)
            2'b00:   return {4{value[7:0]}};
            2'b01:   return {2{value[15:0]}};
            default: return value;
        endcase
    endfunction

    // Select the addressed lane and zero- or sign-extend it to 32 bits.
    function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] width,
                                               input logic [1:0] addr, input logic zext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (width)
            2'b00:   return zext ? {24'b0, b} : 32'(b);
            2'b01:   return zext ? {16'b0, h} : 32'(h);
            default: return word;
        endcase
    endfunction

    // A fence never touches the bus; a flushed instruction never starts an access.
    assign req = (mem_read_in | mem_write_in) & ~flush_in & ~mem_fence_in;

    // Bus request, alignment and stall; reset drops strobes without waiting for a clock.
    always_comb begin
        strobe_en            = reset_n & (((state_q == IDLE) & req) | (state_q == BUSY));
        data_address_out     = {result_in[31:2], 2'b00};
        data_read_out        = strobe_en & mem_read_in;
        data_write_out       = strobe_en & mem_write_in;
        data_write_mask_out  = lane_mask(mem_width_in, result_in[1:0]);
        data_write_value_out = store_lanes(mem_width_in, rs2_value_in);
        stall_out            = strobe_en & ~data_ready_in;
        load_data            = align_load(data_read_value_in, mem_width_in, result_in[1:0],
                                          mem_zero_extend_in);
        wb_load_value        = (state_q == DONE) ? hold_q : load_data;
    end

    // Branch redirect straight to fetch; a flushed instruction never redirects.
    always_comb begin
        case (branch_op_in)
            2'b00:   branch_taken_out = 1'b0;
            2'b01:   branch_taken_out = (result_in == 32'd0);
            2'b10:   branch_taken_out = (result_in != 32'd0);
            default: branch_taken_out = 1'b1;
        endcase
        branch_taken_out = branch_taken_out & ~flush_in;
        branch_pc_out    = branch_pc_in;
    end

    // Access sequencing: a completion under stall parks the load data in the
    // hold buffer so DONE never re-issues the access; flush in BUSY only marks kill.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!data_ready_in) begin
                        state_d = BUSY;
                    end else if (stall_in) begin
                        state_d = DONE;
                        hold_d  = load_data;
                    end
                end
            end
            BUSY: begin
                kill_d = kill_q | flush_in;
                if (data_ready_in) begin
                    kill_d = 1'b0;
                    if (stall_in) begin
                        state_d = DONE;
                        hold_d  = load_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (!stall_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writeback register: bubbles while flushed, waiting or killed; frozen under stall_in.
    always_comb begin
        rd_d       = rd_q;
        rd_write_d = rd_write_q;
        rd_value_d = rd_value_q;
        if (!stall_in) begin
            if (flush_in | stall_out | kill_q) begin
                rd_write_d = 1'b0;
            end else begin
                rd_d       = rd_in;
                rd_write_d = rd_write_in;
                rd_value_d = mem_read_in ? wb_load_value : result_in;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            hold_q     <= 32'd0;
            rd_q       <= 5'd0;
            rd_write_q <= 1'b0;
            rd_value_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            hold_q     <= hold_d;
            rd_q       <= rd_d;
            rd_write_q <= rd_write_d;
            rd_value_q <= rd_value_d;
        end
    end

    assign rd_out       = rd_q;
    assign rd_write_out = rd_write_q;
    assign rd_value_out = rd_value_q;

endmodule

// File: tb/tb_rv32_mem.sv
// tb_rv32_mem: directed bench for the memory-access stage with a writeback scoreboard.
module tb_rv32_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_in, flush_in, mem_read_in, mem_write_in;
    logic [1:0]  mem_width_in;
    logic        mem_zero_extend_in, mem_fence_in;
    logic [1:0]  branch_op_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic [31:0] result_in, rs2_value_in, branch_pc_in;
    logic [31:0] data_address_out;
    logic        data_read_out, data_write_out;
    logic [3:0]  data_write_mask_out;
    logic [31:0] data_write_value_out;
    logic [31:0] data_read_value_in;
    logic        data_ready_in;
    logic        stall_out, branch_taken_out;
    logic [31:0] branch_pc_out;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] rd_value_out;

    rv32_mem dut (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_width_in(mem_width_in),
        .mem_zero_extend_in(mem_zero_extend_in), .mem_fence_in(mem_fence_in),
        .branch_op_in(branch_op_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
        .result_in(result_in), .rs2_value_in(rs2_value_in), .branch_pc_in(branch_pc_in),
        .data_address_out(data_address_out), .data_read_out(data_read_out),
        .data_write_out(data_write_out), .data_write_mask_out(data_write_mask_out),
        .data_write_value_out(data_write_value_out), .data_read_value_in(data_read_value_in),
        .data_ready_in(data_ready_in), .stall_out(stall_out),
        .branch_taken_out(branch_taken_out), .branch_pc_out(branch_pc_out),
        .rd_out(rd_out), .rd_write_out(rd_write_out), .rd_value_out(rd_value_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    wb_t  exp_q[$];
    wb_t  exp_e;
    int   checks = 0;
    int   errors = 0;
    logic upd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_in = 0; flush_in = 0; mem_read_in = 0; mem_write_in = 0;
        mem_width_in = 2'b00; mem_zero_extend_in = 0; mem_fence_in = 0;
        branch_op_in = 2'b00; rd_in = 5'd0; rd_write_in = 0;
        result_in = 32'd0; rs2_value_in = 32'd0; branch_pc_in = 32'd0;
        data_read_value_in = 32'd0; data_ready_in = 0;
    endtask

    // Whether the writeback register was allowed to load at this edge.
    always @(posedge clk) upd <= reset_n & ~stall_in;

    // Scoreboard: every fresh writeback must match the oldest expected entry.
    always @(negedge clk) begin
        if (upd && rd_write_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_spurious_write", {31'd0, rd_write_out}, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wb_rd", 32'(rd_out), 32'(exp_e.rd));
                chk("wb_value", rd_value_out, exp_e.val);
            end
        end
    end

    initial begin
        idle();
        reset_n = 1'b0;
        #2;
        chk("reset_rd_out", 32'(rd_out), 32'd0);
        chk("reset_rd_write", {31'd0, rd_write_out}, 32'd0);
        chk("reset_rd_value", rd_value_out, 32'd0);
        chk("reset_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // Sign-extended byte load, zero wait
        mem_read_in = 1; mem_width_in = 2'b00; mem_zero_extend_in = 0;
        rd_in = 5'd5; rd_write_in = 1; result_in = 32'h0000_1003;
        data_read_value_in = 32'h8012_3456; data_ready_in = 1;
        exp_q.push_back('{rd: 5'd5, val: 32'hFFFF_FF80});
        #1;
        chk("lb_addr", data_address_out, 32'h0000_1000);
        chk("lb_read", {31'd0, data_read_out}, 32'd1);
        chk("lb_write", {31'd0, data_write_out}, 32'd0);
        chk("lb_stall", {31'd0, stall_out}, 32'd0);
        cyc();

        // Zero-extended byte load
        mem_zero_extend_in = 1; rd_in = 5'd6;
        exp_q.push_back('{rd: 5'd6, val: 32'h0000_0080});
        cyc();

        // Sign-extended half load from upper half
        mem_width_in = 2'b01; mem_zero_extend_in = 0; rd_in = 5'd10;
        result_in = 32'h0000_1002; data_read_value_in = 32'h8001_1234;
        exp_q.push_back('{rd: 5'd10, val: 32'hFFFF_8001});
        cyc();

        // Half store
        idle();
        mem_write_in = 1; mem_width_in = 2'b01; result_in = 32'h0000_2002;
        rs2_value_in = 32'h1234_ABCD; data_ready_in = 1;
        #1;
        chk("sh_addr", data_address_out, 32'h0000_2000);
        chk("sh_mask", 32'(data_write_mask_out), 32'h0000_000C);
        chk("sh_data", data_write_value_out, 32'hABCD_ABCD);
        chk("sh_write", {31'd0, data_write_out}, 32'd1);
        cyc();
        chk("sh_no_wb", {31'd0, rd_write_out}, 32'd0);

        // Byte store to lane 1, then word store
        mem_width_in = 2'b00; result_in = 32'h0000_2001;
        #1;
        chk("sb_mask", 32'(data_write_mask_out), 32'h0000_0002);
        chk("sb_data", data_write_value_out, 32'hCDCD_CDCD);
        cyc();
        mem_width_in = 2'b10; result_in = 32'h0000_2003;
        #1;
        chk("sw_mask", 32'(data_write_mask_out), 32'h0000_000F);
        chk("sw_data", data_write_value_out, 32'h1234_ABCD);
        cyc();

        // Word load, ready after 3 wait cycles
        idle();
        mem_read_in = 1; mem_width_in = 2'b10; rd_in = 5'd7; rd_write_in = 1;
        result_in = 32'h0000_3000; data_read_value_in = 32'hDEAD_BEEF; data_ready_in = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_stall", {31'd0, stall_out}, 32'd1);
            chk("lw_wait_read", {31'd0, data_read_out}, 32'd1);
            chk("lw_wait_addr", data_address_out, 32'h0000_3000);
            cyc();
            chk("lw_bubble", {31'd0, rd_write_out}, 32'd0);
        end
        data_ready_in = 1;
        exp_q.push_back('{rd: 5'd7, val: 32'hDEAD_BEEF});
        #1;
        chk("lw_ready_stall", {31'd0, stall_out}, 32'd0);
        chk("lw_ready_read", {31'd0, data_read_out}, 32'd1);
        cyc();
        idle();
        #1;
        chk("lw_after_read", {31'd0, data_read_out}, 32'd0);

        // Plain ALU op
        rd_in = 5'd9; rd_write_in = 1; result_in = 32'h1234_5678;
        exp_q.push_back('{rd: 5'd9, val: 32'h1234_5678});
        cyc();

        // Load completing under stall_in for 2 cycles
        idle();
        mem_read_in = 1; mem_width_in = 2'b00; mem_zero_extend_in = 1;
        rd_in = 5'd8; rd_write_in = 1; result_in = 32'h0000_4001;
        data_read_value_in = 32'h0000_AB00; data_ready_in = 1; stall_in = 1;
        #1;
        chk("ld_stall_read", {31'd0, data_read_out}, 32'd1);
        chk("ld_stall_stall", {31'd0, stall_out}, 32'd0);
        cyc();
        data_read_value_in = 32'h1111_1111;
        #1;
        chk("done_no_reissue", {31'd0, data_read_out}, 32'd0);
        chk("done_hold_rd", 32'(rd_out), 32'd9);
        cyc();
        stall_in = 0;
        exp_q.push_back('{rd: 5'd8, val: 32'h0000_00AB});
        #1;
        chk("done_release_read", {31'd0, data_read_out}, 32'd0);
        cyc();

        // Flush raised while a store waits
        idle();
        mem_write_in = 1; mem_width_in = 2'b10; rd_in = 5'd11; rd_write_in = 1;
        result_in = 32'h0000_5004; rs2_value_in = 32'hCAFE_F00D; data_ready_in = 0;
        cyc();
        flush_in = 1;
        #1;
        chk("fl_write_held", {31'd0, data_write_out}, 32'd1);
        chk("fl_mask_held", 32'(data_write_mask_out), 32'h0000_000F);
        chk("fl_data_held", data_write_value_out, 32'hCAFE_F00D);
        chk("fl_stall", {31'd0, stall_out}, 32'd1);
        cyc();
        flush_in = 0;
        #1;
        chk("fl_write_after", {31'd0, data_write_out}, 32'd1);
        cyc();
        data_ready_in = 1;
        cyc();
        chk("fl_killed_wb", {31'd0, rd_write_out}, 32'd0);
        idle();
        #1;
        chk("fl_idle_write", {31'd0, data_write_out}, 32'd0);
        cyc();

        // Flushed ALU op and fence
        rd_in = 5'd12; rd_write_in = 1; result_in = 32'h0000_0042; flush_in = 1;
        cyc();
        chk("flush_alu_wb", {31'd0, rd_write_out}, 32'd0);
        idle();
        mem_fence_in = 1;
        #1;
        chk("fence_read", {31'd0, data_read_out}, 32'd0);
        chk("fence_write", {31'd0, data_write_out}, 32'd0);
        chk("fence_stall", {31'd0, stall_out}, 32'd0);
        cyc();

        // Branch resolution
        idle();
        branch_op_in = 2'b01; result_in = 32'd0; branch_pc_in = 32'h8000_0100;
        #1;
        chk("br_zero_taken", {31'd0, branch_taken_out}, 32'd1);
        chk("br_pc", branch_pc_out, 32'h8000_0100);
        flush_in = 1;
        #1;
        chk("br_zero_flushed", {31'd0, branch_taken_out}, 32'd0);
        flush_in = 0; result_in = 32'd5;
        #1;
        chk("br_zero_nz", {31'd0, branch_taken_out}, 32'd0);
        branch_op_in = 2'b10;
        #1;
        chk("br_nonzero", {31'd0, branch_taken_out}, 32'd1);
        branch_op_in = 2'b11;
        #1;
        chk("br_always", {31'd0, branch_taken_out}, 32'd1);
        branch_op_in = 2'b00;
        #1;
        chk("br_never", {31'd0, branch_taken_out}, 32'd0);
        cyc();

        // Reset in the middle of a waiting load
        idle();
        mem_read_in = 1; mem_width_in = 2'b10; rd_in = 5'd13; rd_write_in = 1;
        result_in = 32'h0000_6000; data_ready_in = 0;
        cyc();
        #1;
        chk("rst_busy_read", {31'd0, data_read_out}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_read_drop", {31'd0, data_read_out}, 32'd0);
        chk("rst_stall_drop", {31'd0, stall_out}, 32'd0);
        chk("rst_rd_value", rd_value_out, 32'd0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        mem_read_in = 1; mem_width_in = 2'b10; rd_in = 5'd14; rd_write_in = 1;
        result_in = 32'h0000_7000; data_read_value_in = 32'h0BAD_CAFE; data_ready_in = 1;
        exp_q.push_back('{rd: 5'd14, val: 32'h0BAD_CAFE});
        #1;
        chk("post_rst_stall", {31'd0, stall_out}, 32'd0);
        cyc();
        idle();
        cyc();
        cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_mem.md
# rv32_mem

Memory-access stage of the rv32 pipeline, directly downstream of the execute stage. It resolves the branch decision from the execute result, performs data-memory loads and stores over a valid/ready bus, aligns and extends load data, and registers the destination-register write for writeback. While a bus access waits, it stalls the upstream stages and inserts a writeback bubble.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall_in  in  1  hold this stage's output register and FSM (from hazard)
- flush_in  in  1  kill the instruction currently presented (from hazard)
- mem_read_in, mem_write_in  in  1 each  load / store request
- mem_width_in  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_zero_extend_in  in  1  zero- (1) or sign- (0) extend sub-word loads
- mem_fence_in  in  1  fence; no bus activity, completes in one cycle
- branch_op_in  in  2  00 NEVER, 01 ZERO, 10 NON_ZERO, 11 ALWAYS
- rd_in  in  5, rd_write_in  in  1  destination register and write enable
- result_in  in  32  ALU result (address for loads/stores, compare result for branches)
- rs2_value_in  in  32  store data
- branch_pc_in  in  32  branch target
- data_address_out  out  32  {result_in[31:2], 2'b00}
- data_read_out, data_write_out  out  1 each  bus strobes
- data_write_mask_out  out  4  byte-lane enables
- data_write_value_out  out  32  store data replicated to lanes
- data_read_value_in  in  32, data_ready_in  in  1  bus response
- stall_out  out  1  access outstanding; hazard stalls fetch/decode/execute
- branch_taken_out  out  1, branch_pc_out  out  32  redirect to fetch (combinational)
- rd_out  out  5, rd_write_out  out  1, rd_value_out  out  32  registered writeback

## Operation
- req = (mem_read_in | mem_write_in) & !flush_in, sampled in IDLE only.
- FSM states: IDLE, BUSY, DONE. Strobes asserted in IDLE (when req) and BUSY; never in DONE.
  - IDLE: req & !ready -> BUSY; req & ready & stall_in -> DONE; else stay.
  - BUSY: ready & stall_in -> DONE; ready & !stall_in -> IDLE; !ready -> BUSY.
  - DONE: !stall_in -> IDLE.
- In BUSY, address/strobes/mask/data held stable; flush_in cannot abort. flush_in during BUSY sets kill bit; on completion the instruction retires as a bubble; kill clears on leaving BUSY.
- On ready with stall_in high, aligned load data captured in hold buffer; DONE uses it so the access is never re-issued.
- stall_out = strobe asserted & !data_ready_in.
- Write mask: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111. addr[0] ignored for half, addr[1:0] for word. Store data: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
- Load: select lane by same rule, then zero/sign-extend to 32 bits.
- Branch taken: NEVER 0; ZERO result_in==0; NON_ZERO result_in!=0; ALWAYS 1; forced 0 by flush_in. branch_pc_out = branch_pc_in.
- Output register, when !stall_in: if flush_in, stall_out, or kill -> rd_write_out=0; else rd_out=rd_in, rd_write_out=rd_write_in, rd_value_out = load ? load data : result_in. When stall_in, all outputs hold.

## Timing
- Reset: state IDLE, kill 0, hold buffer 0, rd_out 0, rd_write_out 0, rd_value_out 0.
- Zero-wait access (ready in first cycle): stall_out never asserts; writeback result visible one edge later.
- N-wait access: stall_out high N cycles; bubbles to writeback for N cycles; result registered on edge where ready=1.
- Non-memory ops and fences: single cycle, no bus activity.
- Reset mid-access: FSM returns to IDLE immediately; strobes drop asynchronously.

## Test plan
- Sign-extend byte load from 0x1003, bus returns 0x80xxxxxx, ready=1 -> address 0x1000, rd_value_out 0xFFFFFF80, no stall; zero-extend -> 0x00000080.
- Half store rs2=0x1234ABCD to 0x2002 -> mask 1100, data 0xABCDABCD, rd_write_out 0.
- Word load, ready after 3 cycles -> stall_out high 3 cycles, 3 bubbles, then value registered; strobes stable throughout.
- Load completes with stall_in=1 for 2 cycles -> single strobe cycle, DONE held, buffered value written when stall_in drops.
- flush_in raised in BUSY on store -> strobes held until ready, then rd_write_out 0, FSM IDLE.
- branch_op ZERO, result_in 0 -> branch_taken_out 1, branch_pc_out = branch_pc_in; same with flush_in=1 -> 0.
